mig_app_arbiter: RTL and testbench
==================================

Name: mig_app_arbiter

Overview:
- Two-requester arbiter/sequencer in front of the DDR3 MIG user (app_*) interface, in the MIG ui-clock domain.
- Accepts single-beat (128-bit) read/write requests from two clients and grants round-robin.
- Drives the MIG command and write-data handshakes, and routes in-order read returns back to the issuing client through a tag FIFO.
- Replaces hand-sequenced app_en/app_wdf_wren logic in the top level.

Parameters:
- ADDR_W, 28, app_addr width.
- DATA_W, 128, app data width.
- MASK_W, 16, app_wdf_mask width (DATA_W/8).
- RDQ_DEPTH, 8, maximum outstanding reads (tag FIFO depth, power of 2).

Ports:
- w_ui_clk  in  1  MIG ui_clk; all logic on its rising edge.
- w_rst_n  in  1  asynchronous active-low reset.
- init_calib_complete  in  1  MIG calibration done; no request is accepted while it is 0.
- rq0_valid / rq1_valid  in  1  request valid.
- rq0_ready / rq1_ready  out  1  one-cycle pulse: request accepted this cycle.
- rq0_we / rq1_we  in  1  1 = write, 0 = read.
- rq0_addr / rq1_addr  in  ADDR_W  byte address (8-aligned, as MIG expects).
- rq0_wdata / rq1_wdata  in  DATA_W  write data.
- rq0_wmask / rq1_wmask  in  MASK_W  write byte mask (1 = masked).
- rq0_rdata / rq1_rdata  out  DATA_W  read data.
- rq0_rvalid / rq1_rvalid  out  1  one-cycle read return strobe.
- app_addr  out  ADDR_W  to MIG.
- app_cmd  out  3  3'b000 write, 3'b001 read.
- app_en  out  1  to MIG.
- app_wdf_data  out  DATA_W  to MIG.
- app_wdf_mask  out  MASK_W  to MIG.
- app_wdf_wren  out  1  to MIG.
- app_wdf_end  out  1  to MIG.
- app_rdy  in  1  from MIG.
- app_wdf_rdy  in  1  from MIG.
- app_rd_data  in  DATA_W  from MIG.
- app_rd_data_valid  in  1  from MIG.
- err  out  1  sticky: read data returned with empty tag FIFO.

Behaviour:
- Reset (async, w_rst_n=0): state IDLE; all outputs 0 (app_en, app_wdf_wren, app_wdf_end, app_addr, app_cmd, app_wdf_data/mask, rqN_ready, rqN_rvalid, rqN_rdata, err); tag FIFO empty; round-robin pointer = requester 0. Reset mid-transaction abandons it with no completion.
- FSM IDLE:
  - Eligible(N) = rqN_valid && init_calib_complete && (rqN_we || tag FIFO not full).
  - Grant the eligible requester favoured by the pointer, else the other one.
  - On grant: rqN_ready=1 for that cycle; latch addr/we/wdata/wmask; pointer <= other requester.
  - Read grant: push tag N into the FIFO.
  - Go to ISSUE.
- FSM ISSUE (entered the cycle after grant, i.e. app_en asserts 1 cycle after rqN_ready):
  - app_en=1, app_cmd = we ? 000 : 001, app_addr = latched address.
  - Write: app_wdf_wren = app_wdf_end = 1, app_wdf_data/mask = latched values.
  - cmd_done sets when app_en && app_rdy.
  - data_done sets when app_wdf_wren && app_wdf_rdy (reads: preset to 1).
  - Each strobe drops the cycle after its own handshake; the two handshakes complete independently, in either order or together.
  - When both are done (including the completing cycle), go to IDLE. A new grant may occur in that IDLE cycle.
  - Minimum 2 cycles per request.
- Read return:
  - On app_rd_data_valid: pop FIFO head T; rqT_rdata <= app_rd_data and rqT_rvalid=1 next cycle (1-cycle latency). The other rdata holds its value.
  - Push and pop in the same cycle: occupancy unchanged.
  - Full = RDQ_DEPTH entries, which blocks read grants only; writes still proceed.
  - Pop while empty: ignored, err <= 1 (sticky until reset).
- init_calib_complete falling: no new grants; an in-flight ISSUE completes normally.
- Requester must hold valid and fields until ready; the arbiter never drops an accepted request.

Decomposition:
- Shared package/header: CMD_READ = 3'b001, CMD_WRITE = 3'b000, APP_ADDR/DATA/MASK widths, FSM state encodings.
- One sub-module: mig_tag_fifo (1-bit wide, RDQ_DEPTH deep, synchronous push/pop, full/empty, async active-low reset).

Test Plan:
- Calib=0, rq0 write pending → no rq0_ready and app_en=0. Raise calib → rq0_ready pulses, then app_en=app_wdf_wren=1, app_cmd=000, app_addr=0x8.
- Both rqs valid with reads continuously, app_rdy=1 → grants alternate 0,1,0,1; each app_en is 1 cycle; pointer starts at 0.
- Write with app_rdy=1 and app_wdf_rdy held 0 for 3 cycles → app_en drops after 1 cycle, app_wdf_wren stays high 4 cycles, then IDLE.
- 8 reads from rq1, no data returned → 9th read not granted while an rq0 write still is. Return one beat 0xDEAD… → rq1_rvalid=1 and rq1_rdata=0xDEAD…; 9th read then granted.
- Interleaved reads rq0@0x10 and rq1@0x18, returns D0 then D1 → rq0 gets D0, rq1 gets D1, in order.
- app_rd_data_valid with empty FIFO → err=1 and stays 1. Assert w_rst_n=0 mid-ISSUE → all outputs 0 immediately, FIFO empty.

Source files
------------

// File: rtl/mig_app_arbiter_pkg.sv
// Shared constants and types for the MIG app-interface arbiter.
package mig_app_arbiter_pkg;
    localparam int APP_ADDR_W = 28;
    localparam int APP_DATA_W = 128;
    localparam int APP_MASK_W = APP_DATA_W / 8;
    localparam int RDQ_DEPTH_DEF = 8;

    localparam logic [2:0] CMD_WRITE = 3'b000;
    localparam logic [2:0] CMD_READ  = 3'b001;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } arb_state_t;
endpackage

// File: rtl/mig_tag_fifo.sv
// 1-bit tag FIFO recording which requester owns each outstanding read.
module mig_tag_fifo #(
    parameter int DEPTH = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  logic din,
    input  logic pop,
    output logic dout,
    output logic full,
    output logic empty
);
    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0] mem;
    logic [AW:0]      wp;
    logic [AW:0]      rp;

    // Extra pointer bit distinguishes full from empty when indices match.
    assign empty = (wp == rp);
    assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign dout  = mem[rp[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem <= '0;
            wp  <= '0;
            rp  <= '0;
        end else begin
            if (push && !full) begin
                mem[wp[AW-1:0]] <= din;
                wp <= wp + 1'b1;
            end
            if (pop && !empty)
                rp <= rp + 1'b1;
        end
    end
endmodule

// File: rtl/mig_app_arbiter.sv
// Round-robin two-client sequencer in front of the MIG app_* interface,
// with tag-FIFO routing of in-order read returns.
module mig_app_arbiter
    import mig_app_arbiter_pkg::*;
#(
    parameter int ADDR_W    = APP_ADDR_W,
    parameter int DATA_W    = APP_DATA_W,
    parameter int MASK_W    = APP_MASK_W,
    parameter int RDQ_DEPTH = RDQ_DEPTH_DEF
) (
    input  logic              w_ui_clk,
    input  logic              w_rst_n,
    input  logic              init_calib_complete,
    input  logic              rq0_valid,
    input  logic              rq1_valid,
    output logic              rq0_ready,
    output logic              rq1_ready,
    input  logic              rq0_we,
    input  logic              rq1_we,
    input  logic [ADDR_W-1:0] rq0_addr,
    input  logic [ADDR_W-1:0] rq1_addr,
    input  logic [DATA_W-1:0] rq0_wdata,
    input  logic [DATA_W-1:0] rq1_wdata,
    input  logic [MASK_W-1:0] rq0_wmask,
    input  logic [MASK_W-1:0] rq1_wmask,
    output logic [DATA_W-1:0] rq0_rdata,
    output logic [DATA_W-1:0] rq1_rdata,
    output logic              rq0_rvalid,
    output logic              rq1_rvalid,
    output logic [ADDR_W-1:0] app_addr,
    output logic [2:0]        app_cmd,
    output logic              app_en,
    output logic [DATA_W-1:0] app_wdf_data,
    output logic [MASK_W-1:0] app_wdf_mask,
    output logic              app_wdf_wren,
    output logic              app_wdf_end,
    input  logic              app_rdy,
    input  logic              app_wdf_rdy,
    input  logic [DATA_W-1:0] app_rd_data,
    input  logic              app_rd_data_valid,
    output logic              err
);
    arb_state_t  state;
    logic        rr;
    logic        run;
    logic        fifo_full, fifo_empty, fifo_tag;
    logic        elig0, elig1, grant, gsel, g_we;
    logic [ADDR_W-1:0] g_addr;
    logic [DATA_W-1:0] g_wdata;
    logic [MASK_W-1:0] g_wmask;

    // run keeps ready low while reset is asserted and for the first edge after.
    assign elig0 = rq0_valid && init_calib_complete && (rq0_we || !fifo_full);
    assign elig1 = rq1_valid && init_calib_complete && (rq1_we || !fifo_full);
    assign grant = run && (state == ST_IDLE) && (elig0 || elig1);
    assign gsel  = rr ? elig1 : !elig0;

    assign rq0_ready = grant && !gsel;
    assign rq1_ready = grant && gsel;

    assign g_we    = gsel ? rq1_we    : rq0_we;
    assign g_addr  = gsel ? rq1_addr  : rq0_addr;
    assign g_wdata = gsel ? rq1_wdata : rq0_wdata;
    assign g_wmask = gsel ? rq1_wmask : rq0_wmask;

    mig_tag_fifo #(.DEPTH(RDQ_DEPTH)) u_tag_fifo (
        .clk   (w_ui_clk),
        .rst_n (w_rst_n),
        .push  (grant && !g_we),
        .din   (gsel),
        .pop   (app_rd_data_valid),
        .dout  (fifo_tag),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge w_ui_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            state        <= ST_IDLE;
            rr           <= 1'b0;
            run          <= 1'b0;
            app_en       <= 1'b0;
            app_cmd      <= '0;
            app_addr     <= '0;
            app_wdf_wren <= 1'b0;
            app_wdf_end  <= 1'b0;
            app_wdf_data <= '0;
            app_wdf_mask <= '0;
            rq0_rdata    <= '0;
            rq1_rdata    <= '0;
            rq0_rvalid   <= 1'b0;
            rq1_rvalid   <= 1'b0;
            err          <= 1'b0;
        end else begin
            run        <= 1'b1;
            rq0_rvalid <= 1'b0;
            rq1_rvalid <= 1'b0;

            if (app_rd_data_valid) begin
                if (fifo_empty) begin
                    err <= 1'b1;
                end else if (fifo_tag) begin
                    rq1_rdata  <= app_rd_data;
                    rq1_rvalid <= 1'b1;
                end else begin
                    rq0_rdata  <= app_rd_data;
                    rq0_rvalid <= 1'b1;
                end
            end

            case (state)
                ST_IDLE: begin
                    if (grant) begin
                        state        <= ST_ISSUE;
                        rr           <= !gsel;
                        app_en       <= 1'b1;
                        app_cmd      <= g_we ? CMD_WRITE : CMD_READ;
                        app_addr     <= g_addr;
                        app_wdf_wren <= g_we;
                        app_wdf_end  <= g_we;
                        if (g_we) begin
                            app_wdf_data <= g_wdata;
                            app_wdf_mask <= g_wmask;
                        end
                    end
                end
                ST_ISSUE: begin
                    // A deasserted strobe means its handshake already completed.
                    if (app_en && app_rdy)
                        app_en <= 1'b0;
                    if (app_wdf_wren && app_wdf_rdy) begin
                        app_wdf_wren <= 1'b0;
                        app_wdf_end  <= 1'b0;
                    end
                    if ((!app_en || app_rdy) && (!app_wdf_wren || app_wdf_rdy))
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mig_app_arbiter.sv
// Directed bench for mig_app_arbiter with hand-computed expectations.
module tb_mig_app_arbiter;
    logic         clk = 1'b0;
    logic         rst_n;
    logic         calib;
    logic         rq0_valid, rq1_valid, rq0_ready, rq1_ready, rq0_we, rq1_we;
    logic [27:0]  rq0_addr, rq1_addr;
    logic [127:0] rq0_wdata, rq1_wdata, rq0_rdata, rq1_rdata;
    logic [15:0]  rq0_wmask, rq1_wmask;
    logic         rq0_rvalid, rq1_rvalid;
    logic [27:0]  app_addr;
    logic [2:0]   app_cmd;
    logic         app_en, app_wdf_wren, app_wdf_end, app_rdy, app_wdf_rdy;
    logic [127:0] app_wdf_data, app_rd_data;
    logic [15:0]  app_wdf_mask;
    logic         app_rd_data_valid, err;

    int total = 0;
    int bad = 0;

    localparam logic [127:0] WD0  = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [127:0] DEAD = 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF;

    always #5 clk = ~clk;

    mig_app_arbiter dut (
        .w_ui_clk(clk), .w_rst_n(rst_n), .init_calib_complete(calib),
        .rq0_valid(rq0_valid), .rq1_valid(rq1_valid),
        .rq0_ready(rq0_ready), .rq1_ready(rq1_ready),
        .rq0_we(rq0_we), .rq1_we(rq1_we),
        .rq0_addr(rq0_addr), .rq1_addr(rq1_addr),
        .rq0_wdata(rq0_wdata), .rq1_wdata(rq1_wdata),
        .rq0_wmask(rq0_wmask), .rq1_wmask(rq1_wmask),
        .rq0_rdata(rq0_rdata), .rq1_rdata(rq1_rdata),
        .rq0_rvalid(rq0_rvalid), .rq1_rvalid(rq1_rvalid),
        .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en),
        .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask),
        .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
        .app_rdy(app_rdy), .app_wdf_rdy(app_wdf_rdy),
        .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
        .err(err)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        rq0_valid = 1'b0; rq1_valid = 1'b0;
        app_rd_data_valid = 1'b0;
        app_rdy = 1'b1; app_wdf_rdy = 1'b1;
        tick(); tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".en"},   {125'd0, app_en, app_wdf_wren, app_wdf_end}, '0);
        chk({tag, ".addr"}, {97'd0, app_cmd, app_addr}, '0);
        chk({tag, ".wdf"},  app_wdf_data | {112'd0, app_wdf_mask}, '0);
        chk({tag, ".rq"},   {123'd0, rq0_ready, rq1_ready, rq0_rvalid, rq1_rvalid, err}, '0);
        chk({tag, ".rdata"}, rq0_rdata | rq1_rdata, '0);
    endtask

    initial begin
        rst_n = 1'b0; calib = 1'b0;
        rq0_valid = 0; rq1_valid = 0; rq0_we = 0; rq1_we = 0;
        rq0_addr = '0; rq1_addr = '0; rq0_wdata = '0; rq1_wdata = '0;
        rq0_wmask = '0; rq1_wmask = '0;
        app_rdy = 1; app_wdf_rdy = 1; app_rd_data = '0; app_rd_data_valid = 0;
        #1;
        chk_all_zero("reset");
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Calibration gate, then a write issue
        rq0_valid = 1; rq0_we = 1; rq0_addr = 28'h8; rq0_wdata = WD0; rq0_wmask = 16'h00F0;
        #1 chk("nocalib.ready", rq0_ready, 0);
        tick();
        chk("nocalib.en", app_en, 0);
        chk("nocalib.ready2", rq0_ready, 0);
        calib = 1;
        #1 chk("calib.ready", rq0_ready, 1);
        tick();
        rq0_valid = 0;
        #1;
        chk("wr.en", {app_en, app_wdf_wren, app_wdf_end}, 3'b111);
        chk("wr.cmd", app_cmd, 3'b000);
        chk("wr.addr", app_addr, 28'h8);
        chk("wr.data", app_wdf_data, WD0);
        chk("wr.mask", app_wdf_mask, 16'h00F0);
        chk("wr.ready_issue", rq0_ready, 0);
        tick();
        chk("wr.done", {app_en, app_wdf_wren, app_wdf_end}, 3'b000);

        // Round-robin reads, then in-order return routing
        do_reset();
        rq0_valid = 1; rq0_we = 0; rq0_addr = 28'h10;
        rq1_valid = 1; rq1_we = 0; rq1_addr = 28'h18;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rr%0d.ready", i), {rq0_ready, rq1_ready}, (i % 2) ? 2'b01 : 2'b10);
            tick();
            chk($sformatf("rr%0d.en", i), {app_en, app_cmd}, 4'b1001);
            chk($sformatf("rr%0d.addr", i), app_addr, (i % 2) ? 28'h18 : 28'h10);
            chk($sformatf("rr%0d.noready", i), {rq0_ready, rq1_ready}, 2'b00);
            tick();
            chk($sformatf("rr%0d.en_drop", i), app_en, 0);
        end
        rq0_valid = 0; rq1_valid = 0;
        for (int i = 0; i < 4; i++) begin
            app_rd_data_valid = 1; app_rd_data = 128'd100 + 128'(i);
            tick();
            app_rd_data_valid = 0;
            chk($sformatf("ret%0d.rvalid", i), {rq0_rvalid, rq1_rvalid}, (i % 2) ? 2'b01 : 2'b10);
            chk($sformatf("ret%0d.rdata", i), (i % 2) ? rq1_rdata : rq0_rdata, 128'd100 + 128'(i));
        end
        chk("ret.hold0", rq0_rdata, 128'd102);
        chk("ret.err", err, 0);

        // Write data channel stall
        do_reset();
        app_wdf_rdy = 0;
        rq0_valid = 1; rq0_we = 1; rq0_addr = 28'h20;
        #1 chk("stall.ready", rq0_ready, 1);
        tick();
        rq0_valid = 0;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("stall%0d.en", k), {app_en, app_wdf_wren, app_wdf_end}, (k == 0) ? 3'b111 : 3'b011);
            tick();
        end
        app_wdf_rdy = 1;
        #1 chk("stall3.en", {app_en, app_wdf_wren}, 2'b01);
        tick();
        chk("stall.done", {app_en, app_wdf_wren, app_wdf_end}, 3'b000);
        rq1_valid = 1; rq1_we = 0; rq1_addr = 28'h28;
        #1 chk("stall.idle_grant", rq1_ready, 1);
        tick();
        rq1_valid = 0;
        tick();

        // Tag FIFO full blocks reads but not writes
        do_reset();
        rq1_valid = 1; rq1_we = 0; rq1_addr = 28'h40;
        #1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("fill%0d.ready", i), rq1_ready, 1);
            tick(); tick();
        end
        chk("full.rd_block", rq1_ready, 0);
        tick();
        chk("full.rd_block2", rq1_ready, 0);
        rq0_valid = 1; rq0_we = 1; rq0_addr = 28'h48;
        #1 chk("full.wr_ok", {rq0_ready, rq1_ready}, 2'b10);
        tick();
        rq0_valid = 0;
        tick();
        chk("full.rd_block3", rq1_ready, 0);
        app_rd_data_valid = 1; app_rd_data = DEAD;
        tick();
        app_rd_data_valid = 0;
        chk("full.rvalid", {rq0_rvalid, rq1_rvalid}, 2'b01);
        chk("full.rdata", rq1_rdata, DEAD);
        chk("full.rd_unblock", rq1_ready, 1);
        tick();
        rq1_valid = 0;
        tick();

        // Sticky error, then reset in the middle of an issue
        do_reset();
        app_rd_data_valid = 1; app_rd_data = DEAD;
        tick();
        app_rd_data_valid = 0;
        chk("err.set", {err, rq0_rvalid, rq1_rvalid}, 3'b100);
        tick(); tick();
        chk("err.sticky", err, 1);
        rq1_valid = 1; rq1_we = 0; rq1_addr = 28'h50;
        tick();
        rq1_valid = 0;
        tick();
        app_rdy = 0;
        rq0_valid = 1; rq0_we = 1; rq0_addr = 28'h58; rq0_wdata = WD0;
        tick();
        rq0_valid = 0;
        tick();
        chk("mid.issue", {app_en, app_wdf_wren}, 2'b10);
        rst_n = 0;
        #1 chk_all_zero("midrst");
        tick();
        rst_n = 1;
        app_rdy = 1;
        tick();
        app_rd_data_valid = 1;
        tick();
        app_rd_data_valid = 0;
        chk("midrst.fifo_empty", {err, rq0_rvalid, rq1_rvalid}, 3'b100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
